uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_sync_fifo.sv | 89 ++++++++
 rtl/uart_tx_param.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parameterised UART transmitter.
//
// Contents
//   ST_*          : transmitter FSM state encodings (3-bit constants)
//   START_LVL     : line level of the start bit (0)
//   STOP_LVL      : line level of stop bits and of the idle line (1)
//   frame_cfg_t   : per-frame framing options captured when a frame starts
//   parity_bit()  : parity of a zero-extended data word (even or odd)
// -----------------------------------------------------------------------------
package uart_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Frame-field line levels
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Framing options frozen for the duration of one frame
  typedef struct packed {
    logic parity_en;
    logic parity_odd;
    logic two_stop;
  } frame_cfg_t;

  // Data words narrower than 8 bits are zero-extended by the caller, so the
  // extra zero bits do not disturb the XOR reduction.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO holding words waiting to be serialised.
// Storage is a plain array written on push and read through a register on
// pop, so pop_data is valid from the cycle after the pop and stays stable
// until the next pop.
//
// Parameters
//   WIDTH : word width
//   DEPTH : number of entries, power of two, >= 2
//
// Ports
//   clk       in   clock
//   rst       in   synchronous active-high reset (empties the FIFO)
//   push      in   write request; ignored while full
//   push_data in   word to write
//   pop       in   read request; ignored while empty
//   pop_data  out  word read by the most recent pop (registered)
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  number of words held
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] pop_data_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == DEPTH_CNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage and registered read port kept free of reset so the array maps
  // onto RAM primitives.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
    if (pop_ok) begin
      pop_data_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = pop_data_reg;
  assign count    = count_reg;

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parameterised UART transmitter with a TX FIFO. Frames are
//   start (0) | DATA_W data bits LSB first | optional parity | 1 or 2 stops (1)
// Each bit lasts baud_div+1 clk cycles. baud_div and the framing options are
// captured when a word is popped, so changing them mid-frame only affects the
// following frame. Frames queued in the FIFO are sent back-to-back.
//
// Parameters
//   DATA_W     : data bits per frame, 5..8
//   FIFO_DEPTH : TX FIFO entries, power of two, >= 2
//   DIV_W      : width of baud_div
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset; aborts any frame
//   baud_div    in   bit period minus one, in clk cycles
//   parity_en   in   1 = append parity bit
//   parity_odd  in   1 = odd parity, 0 = even parity
//   two_stop    in   1 = two stop bits
//   tx_valid    in   write request
//   tx_data_in  in   word to send
//   tx_ready    out  FIFO can accept a word
//   tx_busy     out  frame in progress or FIFO non-empty
//   fifo_count  out  words held in the FIFO
//   uart_tx_pin out  serial line (registered)
// -----------------------------------------------------------------------------
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          two_stop,
  input  logic                          tx_valid,
  input  logic [DATA_W-1:0]             tx_data_in,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          uart_tx_pin
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

  // FIFO interface
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_W-1:0]     fifo_pop_data;

  // FSM and datapath state
  logic [2:0]            state_reg;
  logic [DIV_W-1:0]      baud_cnt_reg;
  logic [DIV_W-1:0]      div_reg;
  frame_cfg_t            cfg_reg;
  logic [DATA_W-1:0]     shift_reg;
  logic [IDX_W-1:0]      bit_idx_reg;
  logic                  stop_idx_reg;
  logic                  parity_reg;
  logic                  pin_reg;

  // Control strobes
  logic                  bit_done;
  logic                  last_stop;
  logic                  start_frame;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && tx_ready && !rst;
  assign fifo_pop  = start_frame;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (tx_data_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_done    = (baud_cnt_reg == div_reg);
    last_stop   = (state_reg == ST_STOP) && bit_done &&
                  (!cfg_reg.two_stop || stop_idx_reg);
    // A new frame starts from IDLE, or directly out of the final stop bit
    // so that queued words go out without an idle gap.
    start_frame = !fifo_empty && ((state_reg == ST_IDLE) || last_stop);
  end

  // ---------------------------------------------------------------------------
  // Shadow registers: frame timing and format frozen at the pop
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
      cfg_reg <= '0;
    end else if (start_frame) begin
      div_reg            <= baud_div;
      cfg_reg.parity_en  <= parity_en;
      cfg_reg.parity_odd <= parity_odd;
      cfg_reg.two_stop   <= two_stop;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit-period counter, restarted at every bit boundary
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_reg <= '0;
    end else if (state_reg == ST_IDLE || bit_done) begin
      baud_cnt_reg <= '0;
    end else begin
      baud_cnt_reg <= baud_cnt_reg + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM; the line level is registered alongside the state so that
  // uart_tx_pin changes on the same edge as the state does.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      pin_reg      <= STOP_LVL;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      parity_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          pin_reg <= STOP_LVL;
          if (start_frame) begin
            state_reg <= ST_START;
            pin_reg   <= START_LVL;
          end
        end

        ST_START: begin
          // The popped word has been on fifo_pop_data since the first
          // START cycle; load it as the start bit ends.
          if (bit_done) begin
            state_reg   <= ST_DATA;
            shift_reg   <= fifo_pop_data;
            pin_reg     <= fifo_pop_data[0];
            bit_idx_reg <= '0;
            parity_reg  <= parity_bit(8'(fifo_pop_data), cfg_reg.parity_odd);
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            if (bit_idx_reg == LAST_BIT) begin
              if (cfg_reg.parity_en) begin
                state_reg <= ST_PARITY;
                pin_reg   <= parity_reg;
              end else begin
                state_reg    <= ST_STOP;
                pin_reg      <= STOP_LVL;
                stop_idx_reg <= 1'b0;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + IDX_W'(1);
              shift_reg   <= {1'b0, shift_reg[DATA_W-1:1]};
              pin_reg     <= shift_reg[1];
            end
          end
        end

        ST_PARITY: begin
          if (bit_done) begin
            state_reg    <= ST_STOP;
            pin_reg      <= STOP_LVL;
            stop_idx_reg <= 1'b0;
          end
        end

        ST_STOP: begin
          if (last_stop) begin
            if (start_frame) begin
              state_reg <= ST_START;
              pin_reg   <= START_LVL;
            end else begin
              state_reg <= ST_IDLE;
              pin_reg   <= STOP_LVL;
            end
          end else if (bit_done) begin
            // First of two stop bits finished; line stays high.
            stop_idx_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          pin_reg   <= STOP_LVL;
        end
      endcase
    end
  end

  assign uart_tx_pin = pin_reg;
  assign tx_busy     = (state_reg != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
// Directed bench for uart_tx_param. Two instances share clk/rst: an 8-bit one
// with a 4-entry FIFO and a 5-bit one. A negedge recorder stores line, busy,
// ready and count per cycle relative to each test's cycle 0; each test then
// compares the recorded trace with hand-computed frames and timings.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

  logic        clk = 1'b0;
  logic        rst;

  // 8-bit instance
  logic [15:0] baud;
  logic        par_en, par_odd, stop2;
  logic        valid;
  logic [7:0]  data;
  logic        ready, busy, pin;
  logic [2:0]  cnt;

  // 5-bit instance
  logic [15:0] baud5;
  logic        valid5;
  logic [4:0]  data5;
  logic        ready5, busy5, pin5;
  logic [2:0]  cnt5;
  logic        zero5 = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  int cyc  = 0;
  int base = 0;

  logic       tr_pin   [256];
  logic       tr_busy  [256];
  logic       tr_ready [256];
  logic [2:0] tr_cnt   [256];
  logic       tr_pin5  [256];
  logic       tr_busy5 [256];

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .baud_div(baud), .parity_en(par_en),
    .parity_odd(par_odd), .two_stop(stop2), .tx_valid(valid),
    .tx_data_in(data), .tx_ready(ready), .tx_busy(busy),
    .fifo_count(cnt), .uart_tx_pin(pin)
  );

  uart_tx_param #(.DATA_W(5), .FIFO_DEPTH(4), .DIV_W(16)) dut5 (
    .clk(clk), .rst(rst), .baud_div(baud5), .parity_en(zero5),
    .parity_odd(zero5), .two_stop(zero5), .tx_valid(valid5),
    .tx_data_in(data5), .tx_ready(ready5), .tx_busy(busy5),
    .fifo_count(cnt5), .uart_tx_pin(pin5)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int idx;
    idx = cyc - base;
    if (idx >= 0 && idx < 256) begin
      tr_pin[idx]   = pin;
      tr_busy[idx]  = busy;
      tr_ready[idx] = ready;
      tr_cnt[idx]   = cnt;
      tr_pin5[idx]  = pin5;
      tr_busy5[idx] = busy5;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Marks the current cycle as cycle 0 of a test.
  task automatic begin_test();
    @(posedge clk);
    #1;
    base = cyc;
  endtask

  // First cycle in [start, start+len) where the chosen trace differs from val,
  // or -1. sel: 0 = pin, 1 = busy, 2 = pin5, 3 = busy5.
  function automatic int seg_bad(input int sel, input int start, input int len,
                                 input logic val);
    logic v;
    for (int i = start; i < start + len; i++) begin
      case (sel)
        0:       v = tr_pin[i];
        1:       v = tr_busy[i];
        2:       v = tr_pin5[i];
        default: v = tr_busy5[i];
      endcase
      if (v !== val) return i;
    end
    return -1;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [3:0] obs;
    rst = 1'b1;
    valid = 1'b1;          // must be ignored while rst is high
    valid5 = 1'b1;
    data = 8'hA5;
    data5 = 5'h15;
    wait_cyc(3);
    @(negedge clk);
    obs = {pin, busy, ready, (cnt == 3'd0)};
    n_vec++;
    if (obs !== 4'b1011) begin
      n_err++;
      $display("FAIL reset_state: {pin,busy,ready,cnt0} observed %b, expected 1011", obs);
    end
    n_vec++;
    if ({pin5, busy5, ready5, cnt5} !== 6'b101000) begin
      n_err++;
      $display("FAIL reset_state5: {pin,busy,ready,cnt} observed %b, expected 101000",
               {pin5, busy5, ready5, cnt5});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid = 1'b0;
    valid5 = 1'b0;
    wait_cyc(2);
    @(negedge clk);
    n_vec++;
    if ({cnt, busy, pin} !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_valid_ignored: {cnt,busy,pin} observed %b, expected 00001",
               {cnt, busy, pin});
    end
    $display("test_reset: done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_8n1();
    logic [9:0] expf;
    int bad;
    expf = 10'b1010101010;   // start 0, data 0x55 LSB first, stop 1
    baud = 16'd9; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    begin_test();
    valid = 1'b1; data = 8'h55;
    wait_cyc(1);
    valid = 1'b0;
    wait_cyc(110);
    bad = seg_bad(0, 0, 2, 1'b1);
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL 8n1_pre_idle: cycle %0d pin %b, expected 1", bad, tr_pin[bad]);
    end
    for (int b = 0; b < 10; b++) begin
      bad = seg_bad(0, 2 + 10*b, 10, expf[b]);
      n_vec++;
      if (bad >= 0) begin
        n_err++;
        $display("FAIL 8n1_bit%0d: cycle %0d pin %b, expected %b", b, bad, tr_pin[bad], expf[b]);
      end
    end
    bad = seg_bad(0, 102, 8, 1'b1);
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL 8n1_post_idle: cycle %0d pin %b, expected 1", bad, tr_pin[bad]);
    end
    n_vec++;
    if ({tr_busy[101], tr_busy[102]} !== 2'b10) begin
      n_err++;
      $display("FAIL 8n1_busy_end: busy@101,102 observed %b, expected 10",
               {tr_busy[101], tr_busy[102]});
    end
    $display("test_8n1: word 0x55 sent");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_parity();
    logic [10:0] expf [2];
    logic [10:0] obs_a, obs_b;
    expf[0] = 11'b10000000110;  // 0x03 even: parity 0
    expf[1] = 11'b11000000110;  // 0x03 odd : parity 1
    for (int r = 0; r < 2; r++) begin
      baud = 16'd1; par_en = 1'b1; par_odd = (r == 1); stop2 = 1'b0;
      begin_test();
      valid = 1'b1; data = 8'h03;
      wait_cyc(1);
      valid = 1'b0;
      wait_cyc(30);
      for (int b = 0; b < 11; b++) begin
        obs_a[b] = tr_pin[2 + 2*b];
        obs_b[b] = tr_pin[3 + 2*b];
      end
      n_vec++;
      if (obs_a !== expf[r]) begin
        n_err++;
        $display("FAIL parity%0d_frame_first_half: observed %b, expected %b", r, obs_a, expf[r]);
      end
      n_vec++;
      if (obs_b !== expf[r]) begin
        n_err++;
        $display("FAIL parity%0d_frame_second_half: observed %b, expected %b", r, obs_b, expf[r]);
      end
      n_vec++;
      if ({tr_busy[23], tr_busy[24]} !== 2'b10) begin
        n_err++;
        $display("FAIL parity%0d_11_bits: busy@23,24 observed %b, expected 10", r,
                 {tr_busy[23], tr_busy[24]});
      end
      $display("test_parity: odd=%0d word 0x03 sent", r);
    end
    par_en = 1'b0; par_odd = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [10:0] expf [2];
    int bad;
    expf[0] = 11'b11010110100;   // 0x5A, two stop bits
    expf[1] = 11'b11001111000;   // 0x3C, two stop bits
    baud = 16'd3; par_en = 1'b0; stop2 = 1'b1;
    begin_test();
    valid = 1'b1; data = 8'h5A;
    wait_cyc(1);
    data = 8'h3C;
    wait_cyc(1);
    valid = 1'b0;
    wait_cyc(95);
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 11; b++) begin
        bad = seg_bad(0, 2 + 44*f + 4*b, 4, expf[f][b]);
        n_vec++;
        if (bad >= 0) begin
          n_err++;
          $display("FAIL b2b_frame%0d_bit%0d: cycle %0d pin %b, expected %b", f, b, bad,
                   tr_pin[bad], expf[f][b]);
        end
      end
    end
    // Last data bit (0) at 34..37, 8 high cycles 38..45, next start at 46.
    n_vec++;
    if ({tr_pin[37], tr_pin[38], tr_pin[45], tr_pin[46]} !== 4'b0110) begin
      n_err++;
      $display("FAIL b2b_gap: pin@37,38,45,46 observed %b, expected 0110",
               {tr_pin[37], tr_pin[38], tr_pin[45], tr_pin[46]});
    end
    n_vec++;
    if ({tr_busy[89], tr_busy[90]} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_busy_end: busy@89,90 observed %b, expected 10",
               {tr_busy[89], tr_busy[90]});
    end
    stop2 = 1'b0;
    $display("test_back_to_back: words 0x5A 0x3C sent");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fifo_full();
    logic [7:0] words [7];
    int exp_acc [6];
    int acc [6];
    int i, guard, mx;
    logic ok;
    logic [9:0] obs, expf;
    words = '{8'h81, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_acc = '{3, 4, 5, 6, 12, 22};
    baud = 16'd0; par_en = 1'b0; stop2 = 1'b0;
    begin_test();
    valid = 1'b1; data = words[0];          // keeps the transmitter busy
    wait_cyc(1);
    valid = 1'b0;
    wait_cyc(2);
    i = 0; guard = 0;
    while (i < 6 && guard < 200) begin
      valid = 1'b1; data = words[i + 1];
      @(negedge clk);
      ok = ready;
      @(posedge clk);
      #1;
      if (ok) begin
        acc[i] = cyc - base - 1;
        i++;
      end
      guard++;
    end
    valid = 1'b0;
    n_vec++;
    if (i != 6) begin
      n_err++;
      $display("FAIL fifo_writes_accepted: observed %0d, expected 6 (timeout)", i);
    end
    wait_cyc(85 - (cyc - base));
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (i == 6 && acc[k] != exp_acc[k]) begin
        n_err++;
        $display("FAIL fifo_accept_cycle%0d: observed %0d, expected %0d", k, acc[k], exp_acc[k]);
      end else if (i != 6) begin
        n_err++;
        $display("FAIL fifo_accept_cycle%0d: observed none, expected %0d", k, exp_acc[k]);
      end
    end
    n_vec++;
    if ({tr_ready[6], tr_ready[7]} !== 2'b10) begin
      n_err++;
      $display("FAIL fifo_ready_fall: ready@6,7 observed %b, expected 10",
               {tr_ready[6], tr_ready[7]});
    end
    mx = 0;
    for (int c = 0; c < 80; c++) if (int'(tr_cnt[c]) > mx) mx = int'(tr_cnt[c]);
    n_vec++;
    if (mx != 4) begin
      n_err++;
      $display("FAIL fifo_max_count: observed %0d, expected 4", mx);
    end
    for (int k = 0; k < 7; k++) begin
      expf = {1'b1, words[k], 1'b0};
      for (int b = 0; b < 10; b++) obs[b] = tr_pin[2 + 10*k + b];
      n_vec++;
      if (obs !== expf) begin
        n_err++;
        $display("FAIL fifo_frame%0d: observed %b, expected %b", k, obs, expf);
      end
    end
    n_vec++;
    if ({tr_busy[71], tr_busy[72]} !== 2'b10) begin
      n_err++;
      $display("FAIL fifo_busy_end: busy@71,72 observed %b, expected 10",
               {tr_busy[71], tr_busy[72]});
    end
    $display("test_fifo_full: 7 frames queued through 4-deep FIFO");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_abort();
    int bad;
    baud = 16'd9; par_en = 1'b0; stop2 = 1'b0;
    begin_test();
    valid = 1'b1; data = 8'h00;
    wait_cyc(4);
    valid = 1'b0;
    wait_cyc(16);                 // now in cycle 20, inside data bit 0
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(140);
    n_vec++;
    if (tr_cnt[4] !== 3'd3) begin
      n_err++;
      $display("FAIL abort_queued: count@4 observed %0d, expected 3", tr_cnt[4]);
    end
    n_vec++;
    if (tr_pin[20] !== 1'b0) begin
      n_err++;
      $display("FAIL abort_in_data: pin@20 observed %b, expected 0", tr_pin[20]);
    end
    n_vec++;
    if ({tr_pin[21], tr_busy[21], tr_ready[21], tr_cnt[21]} !== 6'b101000) begin
      n_err++;
      $display("FAIL abort_next_cycle: {pin,busy,ready,cnt}@21 observed %b, expected 101000",
               {tr_pin[21], tr_busy[21], tr_ready[21], tr_cnt[21]});
    end
    bad = seg_bad(0, 21, 140, 1'b1);
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL abort_line_quiet: cycle %0d pin %b, expected 1", bad, tr_pin[bad]);
    end
    bad = seg_bad(1, 21, 140, 1'b0);
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL abort_not_busy: cycle %0d busy %b, expected 0", bad, tr_busy[bad]);
    end
    $display("test_reset_abort: frame aborted with 3 words queued");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_width5();
    logic [6:0] obs, expf;
    int bad;
    expf = 7'b1010100;          // 0x0A, 5 bits, 1-cycle bits
    baud5 = 16'd3;
    begin_test();
    valid5 = 1'b1; data5 = 5'h1F;
    wait_cyc(1);
    valid5 = 1'b0;
    wait_cyc(7);                // cycle 8, frame in its data bits
    baud5 = 16'd0;
    wait_cyc(32);               // cycle 40
    valid5 = 1'b1; data5 = 5'h0A;
    wait_cyc(1);
    valid5 = 1'b0;
    wait_cyc(15);
    bad = seg_bad(2, 2, 4, 1'b0);
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL w5_start: cycle %0d pin %b, expected 0", bad, tr_pin5[bad]);
    end
    bad = seg_bad(2, 6, 24, 1'b1);
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL w5_data_stop: cycle %0d pin %b, expected 1", bad, tr_pin5[bad]);
    end
    n_vec++;
    if ({tr_busy5[29], tr_busy5[30]} !== 2'b10) begin
      n_err++;
      $display("FAIL w5_old_period: busy@29,30 observed %b, expected 10",
               {tr_busy5[29], tr_busy5[30]});
    end
    for (int b = 0; b < 7; b++) obs[b] = tr_pin5[42 + b];
    n_vec++;
    if (obs !== expf) begin
      n_err++;
      $display("FAIL w5_new_period_frame: observed %b, expected %b", obs, expf);
    end
    n_vec++;
    if ({tr_busy5[48], tr_busy5[49]} !== 2'b10) begin
      n_err++;
      $display("FAIL w5_new_period_end: busy@48,49 observed %b, expected 10",
               {tr_busy5[48], tr_busy5[49]});
    end
    $display("test_width5: words 0x1F 0x0A sent");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    baud = '0; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    valid = 1'b0; data = '0;
    baud5 = '0; valid5 = 1'b0; data5 = '0;
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_fifo_full();
    test_reset_abort();
    test_width5();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
